rx_cmd_decoder: RTL and testbench

//  Sits directly downstream of the UART receiver. Consumes the received byte stream (RX_P_DATA qualified by RX_D_VLD) and parses

---
 rtl/rx_cmd_if.sv | 32 +++
 rtl/rx_cmd_decoder.sv | 153 +++++++++++++++
 tb/tb_rx_cmd_decoder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_cmd_if.sv
// Byte-stream / command-strobe bundle between the UART RX and the system datapath.
interface rx_cmd_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4
) ();
  logic [DATA_WIDTH-1:0] rx_p_data;
  logic                  rx_d_vld;
  logic                  rx_err;
  logic                  resp_vld;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  alu_en;
  logic [FUN_WIDTH-1:0]  alu_fun;
  logic                  clk_gate_en;
  logic                  busy;
  logic                  cmd_err;

  // Decoder side: consumes bytes and responses, drives strobes.
  modport master (
    input  rx_p_data, rx_d_vld, rx_err, resp_vld,
    output wr_en, rd_en, address, wr_data, alu_en, alu_fun, clk_gate_en, busy, cmd_err
  );

  // Environment side: supplies bytes and responses, observes strobes.
  modport slave (
    output rx_p_data, rx_d_vld, rx_err, resp_vld,
    input  wr_en, rd_en, address, wr_data, alu_en, alu_fun, clk_gate_en, busy, cmd_err
  );
endinterface

// File: rtl/rx_cmd_decoder.sv
// Parses UART command frames into register-file and ALU strobes; stalls on outstanding responses.
module rx_cmd_decoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  rx_cmd_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALO = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OP_A, S_OP_B, S_ALU_FUN, S_WAIT_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  clk_gate_q, clk_gate_d;
  logic                  busy_q, busy_d;

  // State and registered-output flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      addr_lat_q <= '0;
      address_q  <= '0;
      wr_data_q  <= '0;
      alu_fun_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      clk_gate_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_lat_q <= addr_lat_d;
      address_q  <= address_d;
      wr_data_q  <= wr_data_d;
      alu_fun_q  <= alu_fun_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      cmd_err_q  <= cmd_err_d;
      clk_gate_q <= clk_gate_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output decode for each received byte.
  always_comb begin
    state_d    = state_q;
    addr_lat_d = addr_lat_q;
    address_d  = address_q;
    wr_data_d  = wr_data_q;
    alu_fun_d  = alu_fun_q;
    clk_gate_d = clk_gate_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    cmd_err_d  = 1'b0;

    if (state_q == S_WAIT_RESP) begin
      // Any byte here is dropped; a concurrent response still releases the stall.
      if (bus.rx_d_vld) cmd_err_d = 1'b1;
      if (bus.resp_vld) begin
        state_d    = S_IDLE;
        clk_gate_d = 1'b0;
      end
    end else if (bus.rx_d_vld && bus.rx_err) begin
      cmd_err_d  = 1'b1;
      state_d    = S_IDLE;
      clk_gate_d = 1'b0;
    end else if (bus.rx_d_vld) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_p_data == OP_WR) begin
            state_d = S_WR_ADDR;
          end else if (bus.rx_p_data == OP_RD) begin
            state_d = S_RD_ADDR;
          end else if (bus.rx_p_data == OP_ALO) begin
            state_d    = S_OP_A;
            clk_gate_d = 1'b1;
          end else if (bus.rx_p_data == OP_ALU) begin
            state_d    = S_ALU_FUN;
            clk_gate_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        S_WR_ADDR: begin
          // Held privately so ADDRESS only moves together with a strobe.
          addr_lat_d = bus.rx_p_data[ADDR_WIDTH-1:0];
          state_d    = S_WR_DATA;
        end
        S_WR_DATA: begin
          wr_en_d   = 1'b1;
          address_d = addr_lat_q;
          wr_data_d = bus.rx_p_data;
          state_d   = S_IDLE;
        end
        S_RD_ADDR: begin
          rd_en_d   = 1'b1;
          address_d = bus.rx_p_data[ADDR_WIDTH-1:0];
          state_d   = S_WAIT_RESP;
        end
        S_OP_A: begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(0);
          wr_data_d = bus.rx_p_data;
          state_d   = S_OP_B;
        end
        S_OP_B: begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(1);
          wr_data_d = bus.rx_p_data;
          state_d   = S_ALU_FUN;
        end
        S_ALU_FUN: begin
          alu_en_d  = 1'b1;
          alu_fun_d = bus.rx_p_data[FUN_WIDTH-1:0];
          state_d   = S_WAIT_RESP;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.address     = address_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_q;
  assign bus.busy        = busy_q;
  assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Scoreboard bench for rx_cmd_decoder: expected strobes queued at drive time, checked as they appear.
module tb_rx_cmd_decoder;

  typedef struct packed {
    logic [3:0] kind;   // {wr, rd, alu, err}
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] fun;
  } ev_t;

  localparam logic [3:0] K_WR  = 4'b1000;
  localparam logic [3:0] K_RD  = 4'b0100;
  localparam logic [3:0] K_ALU = 4'b0010;
  localparam logic [3:0] K_ERR = 4'b0001;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  ev_t  sb_q[$];

  rx_cmd_if bus ();

  rx_cmd_decoder dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] kind, input logic [3:0] addr, input logic [7:0] data,
                      input logic [3:0] fun);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.fun  = fun;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    @(posedge clk);
    #1;
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    bus.rx_err    = err;
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    bus.rx_d_vld = 1'b0;
    bus.rx_err   = 1'b0;
    bus.resp_vld = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  task automatic resp();
    @(posedge clk);
    #1;
    bus.resp_vld = 1'b1;
    idle(2);
  endtask

  // Compare every strobe cycle against the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:0] kind;
    ev_t        e;
    kind = {bus.wr_en, bus.rd_en, bus.alu_en, bus.cmd_err};
    if (rst_n && kind != 4'b0000) begin
      if (sb_q.size() == 0) begin
        chk("extra_strobe", 32'(kind), 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_kind", 32'(kind), 32'(e.kind));
        if (e.kind == K_WR) begin
          chk("wr_addr", 32'(bus.address), 32'(e.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
        if (e.kind == K_RD) chk("rd_addr", 32'(bus.address), 32'(e.addr));
        if (e.kind == K_ALU) chk("alu_fun", 32'(bus.alu_fun), 32'(e.fun));
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return 32'({bus.wr_en, bus.rd_en, bus.alu_en, bus.cmd_err, bus.clk_gate_en, bus.busy,
                bus.address, bus.wr_data, bus.alu_fun});
  endfunction

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.rx_p_data = '0;
    bus.rx_d_vld  = 1'b0;
    bus.rx_err    = 1'b0;
    bus.resp_vld  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Plain write, then a back-to-back second write.
    send(8'hAA, 1'b0);
    send(8'h05, 1'b0);
    push(K_WR, 4'h5, 8'h3C, 4'h0);
    send(8'h3C, 1'b0);
    send(8'hAA, 1'b0);
    send(8'h26, 1'b0);
    push(K_WR, 4'h6, 8'h11, 4'h0);
    send(8'h11, 1'b0);
    idle(3);
    chk("wr_busy_clear", 32'(bus.busy), 32'h0);
    chk("wr_gate_off", 32'(bus.clk_gate_en), 32'h0);

    // Read with wrapped address, stray byte while waiting, then response.
    send(8'hBB, 1'b0);
    push(K_RD, 4'h3, 8'h0, 4'h0);
    send(8'h13, 1'b0);
    idle(1);
    chk("rd_busy", 32'(bus.busy), 32'h1);
    push(K_ERR, 4'h0, 8'h0, 4'h0);
    send(8'h77, 1'b0);
    idle(3);
    chk("rd_wait_held", 32'(bus.busy), 32'h1);
    resp();
    chk("rd_busy_clear", 32'(bus.busy), 32'h0);

    // RESP_VLD outside WAIT_RESP is ignored.
    resp();
    chk("stray_resp_idle", 32'(bus.busy), 32'h0);

    // ALU with operands; clock gate spans opcode to response.
    send(8'hCC, 1'b0);
    idle(1);
    chk("alu_gate_on", 32'(bus.clk_gate_en), 32'h1);
    push(K_WR, 4'h0, 8'h12, 4'h0);
    send(8'h12, 1'b0);
    push(K_WR, 4'h1, 8'h34, 4'h0);
    send(8'h34, 1'b0);
    push(K_ALU, 4'h0, 8'h0, 4'h1);
    send(8'h01, 1'b0);
    idle(3);
    chk("alu_gate_wait", 32'(bus.clk_gate_en), 32'h1);
    chk("alu_busy_wait", 32'(bus.busy), 32'h1);
    resp();
    chk("alu_gate_off", 32'(bus.clk_gate_en), 32'h0);

    // Errored byte mid-frame aborts it; ADDRESS keeps its last strobed value.
    send(8'hAA, 1'b0);
    send(8'h05, 1'b0);
    push(K_ERR, 4'h0, 8'h0, 4'h0);
    send(8'h3C, 1'b1);
    idle(3);
    chk("err_idle", 32'(bus.busy), 32'h0);
    chk("addr_hold", 32'(bus.address), 32'h1);
    send(8'hAA, 1'b0);
    send(8'h02, 1'b0);
    push(K_WR, 4'h2, 8'hFF, 4'h0);
    send(8'hFF, 1'b0);
    idle(3);

    // Unknown opcode.
    push(K_ERR, 4'h0, 8'h0, 4'h0);
    send(8'h5A, 1'b0);
    idle(3);
    chk("bad_op_idle", 32'(bus.busy), 32'h0);

    // Short ALU frame with wrapped function; response and byte collide in WAIT_RESP.
    send(8'hDD, 1'b0);
    push(K_ALU, 4'h0, 8'h0, 4'h3);
    send(8'hF3, 1'b0);
    idle(2);
    @(posedge clk);
    #1;
    bus.rx_p_data = 8'hCC;
    bus.rx_d_vld  = 1'b1;
    bus.resp_vld  = 1'b1;
    push(K_ERR, 4'h0, 8'h0, 4'h0);
    idle(3);
    chk("collide_idle", 32'(bus.busy), 32'h0);
    chk("collide_gate", 32'(bus.clk_gate_en), 32'h0);

    // Reset mid-frame clears everything with no strobe.
    send(8'hDD, 1'b0);
    idle(1);
    chk("pre_rst_gate", 32'(bus.clk_gate_en), 32'h1);
    send(8'h09, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midframe_rst", all_outs(), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_idle", 32'(bus.busy), 32'h0);
    send(8'hAA, 1'b0);
    send(8'h07, 1'b0);
    push(K_WR, 4'h7, 8'h5E, 4'h0);
    send(8'h5E, 1'b0);
    idle(5);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
